// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Default sizes, the zero word and the arbiter FSM encoding live here.
package rf_write_arbiter_pkg;

  localparam int RF_DATA_W       = 32;
  localparam int RF_ADDR_W       = 5;
  localparam int WB_FIFO_DEPTH   = 4;
  localparam int WB_STARVE_LIMIT = 8;

  localparam logic [RF_DATA_W-1:0] ZERO_WORD = '0;

  // PIPE_PRI: pipeline owns the slot; DRAIN: one forced FIFO pop.
  typedef enum logic {
    PIPE_PRI = 1'b0,
    DRAIN    = 1'b1
  } arb_state_e;

  function automatic logic is_r0(input logic [RF_ADDR_W-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/rf_write_arbiter_wb_fifo.sv
// Registered FIFO for long-latency writeback results. Each entry's valid bit
// and address are exposed so the arbiter can answer pending-register queries.
module wb_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = WB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [DEPTH-1:0]  ent_valid,
  output logic [ADDR_W-1:0] ent_addr [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  // Guarding here keeps the storage consistent even if a caller misbehaves:
  // a full FIFO never pushes, an empty one never pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = ent_addr[rd_ptr];
  assign head_data = ent_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (do_push) begin
        ent_addr[wr_ptr]  <= push_addr;
        ent_data[wr_ptr]  <= push_data;
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Single write port front end of the 32x32 register file: merges the in-order
// pipeline (src0) with buffered long-latency results (src1). Optional macro: WB_FWD_EN.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  // Handshake: a transfer happens on a rising edge where valid && ready, outside reset.
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [ADDR_W-1:0] src0_addr,
  input  logic [DATA_W-1:0] src0_data,
  input  logic              src1_valid,
  output logic              src1_ready,
  input  logic [ADDR_W-1:0] src1_addr,
  input  logic [DATA_W-1:0] src1_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] pend_raddr1,
  input  logic [ADDR_W-1:0] pend_raddr2,
  output logic              pend_hit1,
  output logic              pend_hit2
`ifdef WB_FWD_EN
  ,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
`endif
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_LAST = SC_W'(STARVE_LIMIT - 1);

  arb_state_e        state;
  logic [SC_W-1:0]   starve_cnt;

  logic              src0_wr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [FIFO_DEPTH-1:0] ent_valid;
  logic [ADDR_W-1:0] ent_addr [FIFO_DEPTH];

  logic              fifo_hit1;
  logic              fifo_hit2;
  logic              wr_hit1;
  logic              wr_hit2;

  assign src0_ready = (state == PIPE_PRI);
  assign src1_ready = !fifo_full;

  // r0 writes are accepted and discarded: src0 frees the slot, src1 is never queued.
  assign src0_wr   = !reset && src0_valid && src0_ready && !is_r0(src0_addr);
  assign fifo_push = !reset && src1_valid && !fifo_full && !is_r0(src1_addr);
  assign fifo_pop  = !reset && !fifo_empty && ((state == DRAIN) || !src0_wr);

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_addr (src1_addr),
    .push_data (src1_data),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PIPE_PRI;
      starve_cnt <= '0;
    end else begin
      case (state)
        PIPE_PRI: begin
          if (!fifo_empty && (starve_cnt == STARVE_LAST) && !fifo_pop)
            state <= DRAIN;
        end
        DRAIN:   state <= PIPE_PRI;
        default: state <= PIPE_PRI;
      endcase
      if (fifo_empty || fifo_pop)
        starve_cnt <= '0;
      else
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Address and data hold their last value when the slot goes unused.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= DATA_W'(ZERO_WORD);
    end else if (src0_wr) begin
      rf_we    <= 1'b1;
      rf_waddr <= src0_addr;
      rf_wdata <= src0_data;
    end else if (fifo_pop) begin
      rf_we    <= 1'b1;
      rf_waddr <= head_addr;
      rf_wdata <= head_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  always_comb begin
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == pend_raddr1)) fifo_hit1 = 1'b1;
      if (ent_valid[i] && (ent_addr[i] == pend_raddr2)) fifo_hit2 = 1'b1;
    end
  end

  assign wr_hit1 = rf_we && (rf_waddr == pend_raddr1) && !is_r0(pend_raddr1);
  assign wr_hit2 = rf_we && (rf_waddr == pend_raddr2) && !is_r0(pend_raddr2);

`ifdef WB_FWD_EN
  // The write stage is covered by forwarding, so only queued results stall decode.
  assign pend_hit1 = !is_r0(pend_raddr1) && fifo_hit1;
  assign pend_hit2 = !is_r0(pend_raddr2) && fifo_hit2;
  assign fwd_hit1  = wr_hit1;
  assign fwd_hit2  = wr_hit2;
  assign fwd_data1 = rf_wdata;
  assign fwd_data2 = rf_wdata;
`else
  assign pend_hit1 = !is_r0(pend_raddr1) && (fifo_hit1 || wr_hit1);
  assign pend_hit2 = !is_r0(pend_raddr2) && (fifo_hit2 || wr_hit2);
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a two-source write scoreboard.
// Build with +define+WB_FWD_EN to exercise the forwarding configuration.
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        src0_valid;
  logic        src0_ready;
  logic [4:0]  src0_addr;
  logic [31:0] src0_data;
  logic        src1_valid;
  logic        src1_ready;
  logic [4:0]  src1_addr;
  logic [31:0] src1_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  pend_raddr1;
  logic [4:0]  pend_raddr2;
  logic        pend_hit1;
  logic        pend_hit2;
`ifdef WB_FWD_EN
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Expected writes per source, {addr, data}; each source must retire in order.
  logic [36:0] exp0_q[$];
  logic [36:0] exp1_q[$];

  rf_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .src0_valid  (src0_valid),
    .src0_ready  (src0_ready),
    .src0_addr   (src0_addr),
    .src0_data   (src0_data),
    .src1_valid  (src1_valid),
    .src1_ready  (src1_ready),
    .src1_addr   (src1_addr),
    .src1_data   (src1_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .pend_raddr1 (pend_raddr1),
    .pend_raddr2 (pend_raddr2),
    .pend_hit1   (pend_hit1),
    .pend_hit2   (pend_hit2)
`ifdef WB_FWD_EN
    ,
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data1   (fwd_data1),
    .fwd_data2   (fwd_data2)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers: inputs change 1 time unit after the rising edge,
  // outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: retire observed writes, then record this cycle's handshakes.
  always @(negedge clk) begin
    logic [36:0] got;
    logic        matched;
    if (rf_we) begin
      got     = {rf_waddr, rf_wdata};
      matched = 1'b0;
      if (exp0_q.size() > 0 && exp0_q[0] === got) begin
        void'(exp0_q.pop_front());
        matched = 1'b1;
      end else if (exp1_q.size() > 0 && exp1_q[0] === got) begin
        void'(exp1_q.pop_front());
        matched = 1'b1;
      end
      n_checks++;
      assert (matched)
      else begin
        n_fails++;
        $error("FAIL sb_write: observed %0h expected src0 head %0h or src1 head %0h",
               got, (exp0_q.size() > 0) ? exp0_q[0] : 37'h0, (exp1_q.size() > 0) ? exp1_q[0] : 37'h0);
      end
      n_checks++;
      assert (rf_waddr !== 5'd0)
      else begin
        n_fails++;
        $error("FAIL sb_r0_write: observed waddr %0h expected nonzero", rf_waddr);
      end
    end
    if (!reset) begin
      if (src0_valid && src0_ready && src0_addr != 5'd0) exp0_q.push_back({src0_addr, src0_data});
      if (src1_valid && src1_ready && src1_addr != 5'd0) exp1_q.push_back({src1_addr, src1_data});
    end
  end

  initial begin
    int k;
    int j;
    int low_cnt;
    logic exp_hit;

    // 1. Reset held two cycles with both sources valid
    reset       = 1'b1;
    src0_valid  = 1'b1;
    src0_addr   = 5'd4;
    src0_data   = 32'h0BAD_0004;
    src1_valid  = 1'b1;
    src1_addr   = 5'd6;
    src1_data   = 32'h0BAD_0006;
    pend_raddr1 = 5'd6;
    pend_raddr2 = 5'd4;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("reset_we", rf_we, 1'b0);
      check("reset_waddr", rf_waddr, 5'd0);
      check("reset_wdata", rf_wdata, 32'h0);
    end
    tick();
    reset      = 1'b0;
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    sample();
    check("post_reset_we", rf_we, 1'b0);
    check("post_reset_pend1", pend_hit1, 1'b0);
    check("post_reset_src1_ready", src1_ready, 1'b1);
    check("post_reset_src0_ready", src0_ready, 1'b1);

    // 2. Single pipeline write, one cycle latency
    tick();
    src0_valid  = 1'b1;
    src0_addr   = 5'd3;
    src0_data   = 32'h1234_5678;
    pend_raddr1 = 5'd3;
    sample();
    check("t2_src0_ready", src0_ready, 1'b1);
    check("t2_we_n", rf_we, 1'b0);
    tick();
    src0_valid = 1'b0;
    sample();
    check("t2_we_n1", rf_we, 1'b1);
    check("t2_waddr", rf_waddr, 5'd3);
    check("t2_wdata", rf_wdata, 32'h1234_5678);
`ifdef WB_FWD_EN
    check("t2_pend1_fwd", pend_hit1, 1'b0);
    check("t2_fwd_hit1", fwd_hit1, 1'b1);
    check("t2_fwd_data1", fwd_data1, 32'h1234_5678);
`else
    check("t2_pend1_wstage", pend_hit1, 1'b1);
`endif
    tick();
    sample();
    check("t2_we_n2", rf_we, 1'b0);
    check("t2_waddr_hold", rf_waddr, 5'd3);
    check("t2_wdata_hold", rf_wdata, 32'h1234_5678);

    // 3. Single long-latency result, two cycle latency, pending until written
    tick();
    src1_valid  = 1'b1;
    src1_addr   = 5'd7;
    src1_data   = 32'hA5A5_A5A5;
    pend_raddr1 = 5'd7;
    sample();
    check("t3_src1_ready", src1_ready, 1'b1);
    check("t3_pend1_push_cycle", pend_hit1, 1'b0);
    tick();
    src1_valid = 1'b0;
    sample();
    check("t3_pend1_queued", pend_hit1, 1'b1);
    check("t3_we_pop_cycle", rf_we, 1'b0);
    tick();
    sample();
    check("t3_we", rf_we, 1'b1);
    check("t3_waddr", rf_waddr, 5'd7);
    check("t3_wdata", rf_wdata, 32'hA5A5_A5A5);
`ifdef WB_FWD_EN
    check("t3_fwd_hit1", fwd_hit1, 1'b1);
    check("t3_pend1_fwd", pend_hit1, 1'b0);
`else
    check("t3_pend1_wstage", pend_hit1, 1'b1);
`endif
    tick();
    sample();
    check("t3_we_after", rf_we, 1'b0);
    check("t3_pend1_clear", pend_hit1, 1'b0);

    // 4. Saturating pipeline with one queued result: forced drain after 8 waits
    k           = 0;
    pend_raddr2 = 5'd20;
    for (int i = 0; i < 12; i++) begin
      tick();
      src0_valid = 1'b1;
      src0_addr  = 5'((k % 8) + 1);
      src0_data  = 32'h4000_0000 + 32'(k);
      src1_valid = (i == 0);
      src1_addr  = 5'd20;
      src1_data  = 32'hBEEF_0000;
      sample();
      check($sformatf("t4_src0_ready_c%0d", i), src0_ready, (i != 9));
      exp_hit = (i >= 1 && i <= 9);
`ifndef WB_FWD_EN
      if (i == 10) exp_hit = 1'b1;
`endif
      check($sformatf("t4_pend2_c%0d", i), pend_hit2, exp_hit);
      if (i == 10) begin
        check("t4_drain_we", rf_we, 1'b1);
        check("t4_drain_waddr", rf_waddr, 5'd20);
        check("t4_drain_wdata", rf_wdata, 32'hBEEF_0000);
      end
      if (src0_ready) k++;
    end
    tick();
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    sample();

    // 5. Five long-latency pushes against a saturating pipeline
    k       = 0;
    j       = 0;
    low_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      src0_valid = 1'b1;
      src0_addr  = 5'((k % 8) + 1);
      src0_data  = 32'h5000_0000 + 32'(k);
      src1_valid = (j < 5);
      src1_addr  = 5'(10 + j);
      src1_data  = 32'hC0DE_0000 + 32'(j);
      sample();
      if (c == 0) check("t5_src1_ready_c0", src1_ready, 1'b1);
      if (c == 4) check("t5_src1_full_c4", src1_ready, 1'b0);
      if (c == 9) check("t5_src1_full_c9", src1_ready, 1'b0);
      if (c == 10) check("t5_src1_ready_c10", src1_ready, 1'b1);
      if (!src0_ready) low_cnt++;
      else k++;
      if (src1_valid && src1_ready) j++;
    end
    tick();
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    sample();
    check("t5_pushes", 64'(j), 64'd5);
    check("t5_drain_cycles", 64'(low_cnt), 64'd5);
    check("t5_src1_drained", 64'(exp1_q.size()), 64'd0);

    // 6. r0 on both sources frees the slot for a queued entry
    tick();
    src0_valid  = 1'b1;
    src0_addr   = 5'd5;
    src0_data   = 32'h0000_0055;
    src1_valid  = 1'b1;
    src1_addr   = 5'd9;
    src1_data   = 32'h0000_0099;
    pend_raddr1 = 5'd0;
    pend_raddr2 = 5'd9;
    sample();
    check("t6_src0_ready", src0_ready, 1'b1);
    check("t6_src1_ready", src1_ready, 1'b1);
    tick();
    src0_addr = 5'd0;
    src0_data = 32'hDEAD_0000;
    src1_addr = 5'd0;
    src1_data = 32'hDEAD_0001;
    sample();
    check("t6_src0_ready_r0", src0_ready, 1'b1);
    check("t6_pend2_queued", pend_hit2, 1'b1);
    check("t6_pend1_r0", pend_hit1, 1'b0);
    check("t6_we_src0", rf_we, 1'b1);
    check("t6_waddr_src0", rf_waddr, 5'd5);
    tick();
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    sample();
    check("t6_we_pop", rf_we, 1'b1);
    check("t6_waddr_pop", rf_waddr, 5'd9);
    check("t6_wdata_pop", rf_wdata, 32'h0000_0099);
    check("t6_pend1_r0_busy", pend_hit1, 1'b0);
    tick();
    sample();
    check("t6_we_idle", rf_we, 1'b0);
    check("t6_pend2_clear", pend_hit2, 1'b0);

    // Final report
    repeat (3) tick();
    sample();
    check("end_src0_queue_empty", 64'(exp0_q.size()), 64'd0);
    check("end_src1_queue_empty", 64'(exp1_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
